// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared definitions for the display scheduler slice: FSM state
//               encoding, value width, saturation limit and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Scheduler FSM encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    // Displayed value width and the largest value the two-digit converter shows
    localparam int         c_VAL_W     = 7;
    localparam logic [6:0] c_SAT_LIMIT = 7'd99;

    // Clamp a raw 7-bit request value into the 0..99 display range
    function automatic logic [c_VAL_W-1:0] sat_val(input logic [c_VAL_W-1:0] x);
        return (x > c_SAT_LIMIT) ? c_SAT_LIMIT : x;
    endfunction

    // Index of the set bit of a one-hot 3-bit grant (0 when empty)
    function automatic logic [1:0] onehot_to_idx(input logic [2:0] g);
        return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter3.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter3
// Description : Combinational 3-way round-robin arbiter. The search starts at
//               the requester after the last owner (mod 3); the result is
//               one-hot, or zero when nothing is requested.
// Ports       : req   [2:0] level requests
//               last  [1:0] index of the previous owner (3 treated like 2)
//               grant [2:0] one-hot winner
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        case (last)
            2'd0: begin
                // search order 1, 2, 0
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            2'd1: begin
                // search order 2, 0, 1
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                // search order 0, 1, 2 (also the post-reset order)
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : display_scheduler
// Description : Shares one two-digit display between three requesters. A
//               granted value is shown for one GRANT cycle plus HOLD_CYC hold
//               cycles, with no preemption; owners rotate round-robin. An
//               optional per-requester blink gates the digit enable.
// Ports       : clk, rst_n         clock, async active-low reset
//               req   [2:0]        level requests
//               vals  [20:0]       packed 7-bit values, requester i at [7i+6:7i]
//               lzreq [2:0]        per-requester leading-zero option
//               blink [2:0]        per-requester blink option
//               ack   [2:0]        one-cycle grant pulse
//               busy               high in GRANT and HOLD
//               owner [1:0]        last granted requester
//               n     [6:0]        value to the digit converter (0..99)
//               lz                 leading-zero option to the converter
//               pulse              digit enable to the converter (1 = lit)
// Revision    : 1.0 - initial release
// ============================================================================
module display_scheduler
    import display_pkg::*;
#(
    parameter int HOLD_CYC   = 1000,
    parameter int BLINK_HALF = 250
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           req,
    input  logic [3*c_VAL_W-1:0] vals,
    input  logic [2:0]           lzreq,
    input  logic [2:0]           blink,
    output logic [2:0]           ack,
    output logic                 busy,
    output logic [1:0]           owner,
    output logic [c_VAL_W-1:0]   n,
    output logic                 lz,
    output logic                 pulse
);

    localparam int HW = (HOLD_CYC   > 1) ? $clog2(HOLD_CYC)   : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [HW-1:0] c_HOLD_LOAD = HW'(HOLD_CYC - 1);
    localparam logic [BW-1:0] c_BLINK_END = BW'(BLINK_HALF - 1);

    logic [1:0]         r_state;
    logic [HW-1:0]      r_hold_cnt;
    logic [BW-1:0]      r_blink_cnt;
    logic               r_blink;
    logic [2:0]         r_ack;
    logic [1:0]         r_owner;
    logic [c_VAL_W-1:0] r_n;
    logic               r_lz;
    logic               r_pulse;

    logic [2:0]         w_grant;
    logic [1:0]         w_idx;
    logic [c_VAL_W-1:0] w_raw;
    logic               w_hold_done;
    logic               w_take;

    rr_arbiter3 u_arb (
        .req   (req),
        .last  (r_owner),
        .grant (w_grant)
    );

    assign w_idx       = onehot_to_idx(w_grant);
    assign w_hold_done = (r_state == c_HOLD) && (r_hold_cnt == '0);

    // A grant is taken on the edge that enters GRANT, either from IDLE or
    // straight from the last HOLD cycle, so ack/owner/n/lz appear in GRANT.
    assign w_take = (req != 3'b000) && ((r_state == c_IDLE) || w_hold_done);

    always_comb begin
        case (w_idx)
            2'd0:    w_raw = vals[c_VAL_W-1:0];
            2'd1:    w_raw = vals[2*c_VAL_W-1:c_VAL_W];
            default: w_raw = vals[3*c_VAL_W-1:2*c_VAL_W];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
            r_ack       <= 3'b000;
            r_owner     <= 2'd2;
            r_n         <= '0;
            r_lz        <= 1'b0;
            r_pulse     <= 1'b1;
        end else begin
            r_ack <= 3'b000;

            case (r_state)
                c_IDLE: begin
                    r_pulse <= 1'b1;
                    if (w_take) begin
                        r_state <= c_GRANT;
                    end
                end
                c_GRANT: begin
                    // Hold starts with the display lit and the blink phase reset
                    r_state     <= c_HOLD;
                    r_hold_cnt  <= c_HOLD_LOAD;
                    r_blink_cnt <= '0;
                    r_pulse     <= 1'b1;
                end
                c_HOLD: begin
                    if (w_hold_done) begin
                        r_state     <= w_take ? c_GRANT : c_IDLE;
                        r_blink_cnt <= '0;
                        r_pulse     <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                        if (r_blink) begin
                            if (r_blink_cnt == c_BLINK_END) begin
                                r_blink_cnt <= '0;
                                r_pulse     <= ~r_pulse;
                            end else begin
                                r_blink_cnt <= r_blink_cnt + 1'b1;
                            end
                        end else begin
                            r_pulse <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_pulse <= 1'b1;
                end
            endcase

            // Winner's value and options are captured together and then
            // frozen until the next grant.
            if (w_take) begin
                r_ack   <= w_grant;
                r_owner <= w_idx;
                r_n     <= sat_val(w_raw);
                r_lz    <= lzreq[w_idx];
                r_blink <= blink[w_idx];
            end
        end
    end

    assign ack   = r_ack;
    assign busy  = (r_state == c_GRANT) || (r_state == c_HOLD);
    assign owner = r_owner;
    assign n     = r_n;
    assign lz    = r_lz;
    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scheduler
// Description : Self-checking bench for display_scheduler with HOLD_CYC=4 and
//               BLINK_HALF=2. A transaction-level reference model tracks the
//               position inside the current display window and derives every
//               expected output arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scheduler;

    localparam int HOLD_CYC   = 4;
    localparam int BLINK_HALF = 2;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [20:0] vals;
    logic [2:0]  lzreq;
    logic [2:0]  blink;
    logic [2:0]  ack;
    logic        busy;
    logic [1:0]  owner;
    logic [6:0]  n;
    logic        lz;
    logic        pulse;

    int tests;
    int fails;

    // Reference model: m_pos = -1 when idle, 0 in the grant cycle,
    // 1..HOLD_CYC during the hold.
    int m_pos;
    int m_owner;
    int m_n;
    int m_lz;
    int m_blink;
    int m_ack;

    display_scheduler #(
        .HOLD_CYC   (HOLD_CYC),
        .BLINK_HALF (BLINK_HALF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .vals  (vals),
        .lzreq (lzreq),
        .blink (blink),
        .ack   (ack),
        .busy  (busy),
        .owner (owner),
        .n     (n),
        .lz    (lz),
        .pulse (pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos   = -1;
        m_owner = 2;
        m_n     = 0;
        m_lz    = 0;
        m_blink = 0;
        m_ack   = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_step(input logic [2:0] r, input logic [20:0] v,
                              input logic [2:0] lzr, input logic [2:0] bl);
        int w;
        int c;
        int raw;
        if (m_pos < 0 || m_pos == HOLD_CYC) begin
            if (r != 3'b000) begin
                w = -1;
                for (int k = 1; k <= 3; k++) begin
                    c = (m_owner + k) % 3;
                    if (w < 0 && r[c]) w = c;
                end
                raw     = int'((v >> (7 * w)) & 21'h7f);
                m_owner = w;
                m_n     = (raw > 99) ? 99 : raw;
                m_lz    = int'(lzr[w]);
                m_blink = int'(bl[w]);
                m_ack   = 1 << w;
                m_pos   = 0;
            end else begin
                m_pos = -1;
                m_ack = 0;
            end
        end else begin
            m_pos++;
            m_ack = 0;
        end
    endtask

    function automatic int exp_pulse();
        if (m_pos <= 0 || m_blink == 0) return 1;
        return (((m_pos - 1) / BLINK_HALF) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".ack"},   32'(ack),   32'(m_ack));
        chk({tag, ".busy"},  32'(busy),  32'(m_pos >= 0));
        chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
        chk({tag, ".n"},     32'(n),     32'(m_n));
        chk({tag, ".lz"},    32'(lz),    32'(m_lz));
        chk({tag, ".pulse"}, 32'(pulse), 32'(exp_pulse()));
    endtask

    // One clock: step the model on the edge, check 1 time unit later
    task automatic tick(input string tag);
        @(posedge clk);
        model_step(req, vals, lzreq, blink);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] seen;
        logic [5:0] seq;
        int         busy_cnt;
        int         grant_no;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req   = '0;
        vals  = '0;
        lzreq = '0;
        blink = '0;
        model_reset();

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ack",   32'(ack),   32'd0);
        chk("rst.busy",  32'(busy),  32'd0);
        chk("rst.owner", 32'(owner), 32'd2);
        chk("rst.n",     32'(n),     32'd0);
        chk("rst.lz",    32'(lz),    32'd0);
        chk("rst.pulse", 32'(pulse), 32'd1);
        rst_n = 1'b1;

        // ---- single request, grant one cycle after release
        vals  = 21'd42;
        lzreq = 3'b001;
        req   = 3'b001;
        tick("single.grant");
        chk("single.ack", 32'(ack), 32'b001);
        chk("single.n",   32'(n),   32'd42);
        chk("single.lz",  32'(lz),  32'd1);
        req      = 3'b000;
        lzreq    = 3'b000;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            tick("single.hold");
            if (busy) busy_cnt++;
        end
        chk("single.busy_cycles", 32'(busy_cnt), 32'd5);
        chk("single.n_held",      32'(n),        32'd42);

        // ---- saturation
        vals = {7'd0, 7'd120, 7'd0};
        req  = 3'b010;
        tick("sat.grant");
        chk("sat.n", 32'(n), 32'd99);
        req = 3'b000;
        repeat (6) tick("sat.hold");

        // ---- simultaneous requests from the post-reset order
        do_reset();
        vals     = {7'd30, 7'd20, 7'd10};
        req      = 3'b111;
        grant_no = 0;
        for (int i = 0; i < 20; i++) begin
            tick("rr");
            if (i % 5 == 0) begin
                chk("rr.ack_order", 32'(ack), 32'(1 << (grant_no % 3)));
                grant_no++;
            end else begin
                chk("rr.ack_quiet", 32'(ack), 32'd0);
            end
        end
        req = 3'b000;
        repeat (6) tick("rr.drain");

        // ---- blink on requester 2; input blink dropped mid-hold must not matter
        vals  = {7'd55, 7'd0, 7'd0};
        blink = 3'b100;
        req   = 3'b100;
        seq   = '0;
        for (int i = 0; i < 6; i++) begin
            tick("blink1");
            seq = {seq[4:0], pulse};
            req = 3'b000;
            if (i == 1) blink = 3'b000;
        end
        chk("blink1.seq", 32'(seq), 32'b111001);

        // ---- no blink
        req = 3'b100;
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            tick("blink0");
            seq = {seq[4:0], pulse};
            req = 3'b000;
        end
        chk("blink0.seq", 32'(seq), 32'b111111);

        // ---- dropped request raised and released during HOLD
        req = 3'b010;
        tick("drop.grant");
        req  = 3'b000;
        seen = '0;
        tick("drop.h1");
        req = 3'b001;
        tick("drop.h2");
        seen |= ack;
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick("drop.tail");
            seen |= ack;
        end
        chk("drop.no_ack0", 32'(seen[0]), 32'd0);
        chk("drop.idle",    32'(busy),    32'd0);

        // ---- reset in the middle of a hold
        vals = {7'd0, 7'd0, 7'd77};
        req  = 3'b001;
        tick("rstmid.grant");
        req = 3'b000;
        tick("rstmid.h1");
        chk("rstmid.n77", 32'(n), 32'd77);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rstmid.n",     32'(n),     32'd0);
        chk("rstmid.busy",  32'(busy),  32'd0);
        chk("rstmid.pulse", 32'(pulse), 32'd1);
        chk("rstmid.ack",   32'(ack),   32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("rstmid.quiet");
            chk("rstmid.no_ack", 32'(ack), 32'd0);
        end
        req = 3'b001;
        tick("rstmid.regrant");
        chk("rstmid.ack_new", 32'(ack), 32'b001);
        req = 3'b000;

        // ---- randomized traffic
        for (int i = 0; i < 400; i++) begin
            req   = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            vals  = 21'($urandom);
            lzreq = 3'($urandom_range(0, 7));
            blink = 3'($urandom_range(0, 7));
            tick("rand");
            chk("rand.onehot", 32'($countones(ack) <= 1), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter HOLD_CYC, default 1000: number of cycles a granted value is held on the display (minimum 2).
REQ-002 Parameter BLINK_HALF, default 250: number of cycles per blink half-period (minimum 1).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  3  level request per requester i (0..2).
REQ-006 vals  input  21  packed request values; requester i uses bits [7i+6:7i].
REQ-007 lzreq  input  3  per-requester leading-zero option, passed to lz while that requester owns the display.
REQ-008 blink  input  3  per-requester blink option, applied while that requester owns the display.
REQ-009 ack  output  3  one-cycle grant pulse per requester.
REQ-010 busy  output  1  high in the GRANT and HOLD states.
REQ-011 owner  output  2  index of the last granted requester.
REQ-012 n  output  7  value to the digit converter, range 0..99.
REQ-013 lz  output  1  leading-zero option to the digit converter.
REQ-014 pulse  output  1  digit enable to the converter; 1 = lit.

Function
REQ-015 The FSM SHALL have three states: IDLE, GRANT and HOLD.
REQ-016 In IDLE with req != 0, the FSM SHALL go to GRANT on the next edge; with req == 0 it SHALL stay in IDLE.
REQ-017 On entering GRANT, the FSM SHALL select the winner by round-robin, with the search starting at owner+1 mod 3; after reset, requester 0 SHALL have top priority.
REQ-018 GRANT SHALL last exactly one cycle, and in that cycle ack[winner]=1, owner=winner, n=sat(vals_winner), lz=lzreq[winner] are all registered together.
REQ-019 The requester's value SHALL reach n in the cycle after req is first sampled in IDLE, giving a latency of 1 cycle.
REQ-020 sat(x) SHALL equal x for x<=99 and 99 for 100..127.
REQ-021 The lzreq and blink bits of the winner SHALL be latched at GRANT; later input changes SHALL be ignored until the next grant.
REQ-022 GRANT SHALL always be followed by HOLD, which lasts exactly HOLD_CYC cycles, counted by a down-counter loaded with HOLD_CYC-1.
REQ-023 When the HOLD counter reaches 0, the FSM SHALL go to GRANT if req != 0 and to IDLE otherwise.
REQ-024 There SHALL be no preemption: requests arriving during GRANT or HOLD wait.
REQ-025 A req deasserted before it is granted SHALL be dropped silently.
REQ-026 A requester that keeps req high after its ack SHALL be re-served in round-robin order, receiving a new ack pulse each time.
REQ-027 When several requests are raised in the same cycle, exactly one ack SHALL assert; ack SHALL be one-hot or zero in every cycle.
REQ-028 With the latched blink bit = 0, pulse SHALL stay at 1.
REQ-029 With the latched blink bit = 1, pulse SHALL be 1 in the GRANT cycle and then toggle every BLINK_HALF cycles during HOLD, driven by a blink counter reset at GRANT.
REQ-030 In IDLE, n, lz and owner SHALL keep their last values, and pulse SHALL be 1.
REQ-031 busy SHALL be 1 exactly when the state is GRANT or HOLD.

Reset
REQ-032 When rst_n=0, the block SHALL immediately force state=IDLE, ack=0, busy=0, owner=2 (so requester 0 is searched first), n=0, lz=0, pulse=1, and clear both counters.
REQ-033 Reset asserted mid-GRANT or mid-HOLD SHALL abort the hold, with no ack pulse after reset deassertion until a new request is sampled in IDLE.
REQ-034 The first edge after rst_n rises SHALL be able to sample req, so a grant is possible 1 cycle after release.

Structure
REQ-035 A shared package display_pkg SHALL hold the state encoding (IDLE/GRANT/HOLD), the saturation limit 99 and the value width 7.
REQ-036 The round-robin selection SHALL be a combinational sub-module rr_arbiter3 (inputs req and last owner; output a one-hot grant); the FSM, counters and output registers stay in display_scheduler.
REQ-037 The outputs n, lz and pulse SHALL connect directly to the team's two-digit decimal converter (inputs n, lz, pulse) without extra logic.

Verification
REQ-038 The bench SHALL use HOLD_CYC=4 and BLINK_HALF=2 for all directed scenarios below.
REQ-039 Single request, req=001, val0=42, lzreq0=1 for 1 cycle -> ack=001 one cycle later, n=42, lz=1, busy high for 5 cycles, then IDLE with n=42 held.
REQ-040 Saturation, val1=120 granted -> n=99.
REQ-041 Simultaneous requests, req=111 held high -> grants in order 0,1,2,0 with one-hot ack, each grant 5 cycles apart.
REQ-042 Blink, blink2=1 granted -> pulse reads 1,1,1,0,0 over GRANT and the 4 HOLD cycles, then 1 in IDLE; with blink=0, pulse stays 1 throughout.
REQ-043 Dropped request, req0 pulsed during HOLD and released before HOLD ends -> no ack[0], and the FSM returns to IDLE.
REQ-044 Reset mid-operation, rst_n low during HOLD of val=77 -> n=0, busy=0, pulse=1 immediately, with no ack until a new request arrives.
